// File: rtl/lock_pump_sequencer.sv
// Lock pump controller: turns a fill/drain request into rate-limited inc/dec
// pulses until the water level sits in the target door's openable band.
module lock_pump_sequencer #(
    parameter int unsigned INNER         = 5600,
    parameter int unsigned OUTER         = 2800,
    parameter int unsigned TOLERANCE     = 168,
    parameter int unsigned PUMP_PERIOD   = 2,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned MAX_PULSES    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_fill,
    input  logic        i_req_drain,
    input  logic        i_abort,
    input  logic        i_doors_closed,
    input  logic [31:0] i_water_level,
    output logic        o_inc_pulse,
    output logic        o_dec_pulse,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic [2:0]  o_state,
    output logic [7:0]  o_pulse_count
);

    localparam int PH_W = (PUMP_PERIOD > 2) ? $clog2(PUMP_PERIOD) : 1;
    localparam int ST_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [31:0] INNER_LO = 32'(INNER - TOLERANCE);
    localparam logic [31:0] OUTER_HI = 32'(OUTER + TOLERANCE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_DRAIN  = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PH_W-1:0] r_phase, w_phase_nxt;
    logic [ST_W-1:0] r_settle, w_settle_nxt;
    logic [7:0]      r_pcount, w_pcount_nxt;
    logic            r_from_fill, w_from_fill_nxt;
    logic            w_inc, w_dec;
    logic            w_at_inner, w_at_outer, w_target;

    assign w_at_inner = i_water_level > INNER_LO;
    assign w_at_outer = i_water_level < OUTER_HI;
    // SETTLE needs to know which band it is holding, so the direction is remembered.
    assign w_target   = r_from_fill ? w_at_inner : w_at_outer;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_settle    <= '0;
            r_pcount    <= '0;
            r_from_fill <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_settle    <= w_settle_nxt;
            r_pcount    <= w_pcount_nxt;
            r_from_fill <= w_from_fill_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_settle_nxt    = r_settle;
        w_pcount_nxt    = r_pcount;
        w_from_fill_nxt = r_from_fill;
        w_inc           = 1'b0;
        w_dec           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((i_req_fill ^ i_req_drain) && i_doors_closed) begin
                    w_from_fill_nxt = i_req_fill;
                    w_pcount_nxt    = '0;
                    w_phase_nxt     = '0;
                    if (i_req_fill)
                        w_state_nxt = w_at_inner ? S_DONE : S_FILL;
                    else
                        w_state_nxt = w_at_outer ? S_DONE : S_DRAIN;
                end
            end
            S_FILL, S_DRAIN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!i_doors_closed) begin
                    w_state_nxt = S_FAULT;
                end else if (w_target) begin
                    w_state_nxt  = S_SETTLE;
                    w_settle_nxt = '0;
                end else if (r_pcount == 8'(MAX_PULSES)) begin
                    w_state_nxt = S_FAULT;
                end else if (r_phase == PH_W'(PUMP_PERIOD - 1)) begin
                    w_inc       = (r_state == S_FILL);
                    w_dec       = (r_state == S_DRAIN);
                    w_phase_nxt = '0;
                    if (r_pcount != 8'hFF)
                        w_pcount_nxt = r_pcount + 8'd1;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            S_SETTLE: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!i_doors_closed) begin
                    w_state_nxt = S_FAULT;
                end else if (!w_target) begin
                    // Band slipped away: resume pumping, keep the pulse tally.
                    w_state_nxt = r_from_fill ? S_FILL : S_DRAIN;
                    w_phase_nxt = '0;
                end else if (r_settle == ST_W'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_settle_nxt = r_settle + ST_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_FAULT: if (i_abort) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_inc_pulse   = w_inc;
    assign o_dec_pulse   = w_dec;
    assign o_busy        = (r_state == S_FILL) || (r_state == S_DRAIN) || (r_state == S_SETTLE);
    assign o_done        = (r_state == S_DONE);
    assign o_fault       = (r_state == S_FAULT);
    assign o_state       = r_state;
    assign o_pulse_count = r_pcount;

endmodule

// File: tb/tb_lock_pump_sequencer.sv
// Self-checking bench for lock_pump_sequencer: table of whole operations plus
// hand-written interlock / abort / band-loss / reset sequences, with a water model.
module tb_lock_pump_sequencer;

    logic        clk = 1'b0;
    logic        reset, req_fill, req_drain, abort, doors;
    logic [31:0] water;
    logic        o_inc_pulse, o_dec_pulse, o_busy, o_done, o_fault;
    logic [2:0]  o_state;
    logic [7:0]  o_pulse_count;

    lock_pump_sequencer dut (
        .clk(clk), .reset(reset), .i_req_fill(req_fill), .i_req_drain(req_drain),
        .i_abort(abort), .i_doors_closed(doors), .i_water_level(water),
        .o_inc_pulse(o_inc_pulse), .o_dec_pulse(o_dec_pulse), .o_busy(o_busy),
        .o_done(o_done), .o_fault(o_fault), .o_state(o_state),
        .o_pulse_count(o_pulse_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned level;
        bit fill, drain, doors, model;
        int n_inc, n_dec, pcount;
        bit exp_done, exp_fault;
        int settle;
    } row_t;

    typedef struct { bit fault; int pcount; } ev_t;

    ev_t  sb[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, n_inc, n_dec, n_done, n_settle, first_cyc, last_cyc, req_cyc;
    bit   model_on = 1'b1, prev_fault = 1'b0, ev_seen, spacing_en;
    logic [2:0] s_state;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_op();
        n_inc = 0; n_dec = 0; n_done = 0; n_settle = 0;
        first_cyc = -1; last_cyc = -1; ev_seen = 0; spacing_en = 1;
    endtask

    task automatic sb_pop(input bit isf);
        ev_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected: got event fault=%0d pcount=%0d expected none", isf, o_pulse_count);
        end else begin
            e = sb.pop_front();
            chk("sb_event", int'({isf, o_pulse_count}), int'({e.fault, 8'(e.pcount)}));
        end
        ev_seen = 1;
    endtask

    // One clock: sample at the falling edge, then apply the water model after the rise.
    task automatic step();
        logic si, sd;
        int t;
        @(negedge clk);
        si = o_inc_pulse; sd = o_dec_pulse;
        if (si || sd) chk("pulse_excl", int'(si && sd), 0);
        chk("busy_map", int'(o_busy), int'(o_state >= 3'd1 && o_state <= 3'd3));
        if (o_state == 3'd3) n_settle++;
        if (si || sd) begin
            if (first_cyc < 0) first_cyc = cyc;
            else if (spacing_en) chk("pulse_spacing", cyc - last_cyc, 2);
            last_cyc = cyc;
        end
        if (si) n_inc++;
        if (sd) n_dec++;
        if (o_done) begin n_done++; sb_pop(1'b0); end
        if (o_fault && !prev_fault) sb_pop(1'b1);
        prev_fault = o_fault;
        s_state = o_state;
        @(posedge clk); #1;
        cyc++;
        if (model_on && !reset) begin
            if (si) begin t = int'(water) + 350; if (t > 5600) t = 5600; water = 32'(t); end
            if (sd) begin t = int'(water) - 400; if (t < 2800) t = 2800; water = 32'(t); end
        end
    endtask

    task automatic wait_event(input string name);
        for (int k = 0; k < 300 && !ev_seen; k++) step();
        if (!ev_seen) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_state"}, int'(o_state), 0);
        chk({name, "_pcount"}, int'(o_pulse_count), 0);
        chk({name, "_flags"}, int'({o_inc_pulse, o_dec_pulse, o_busy, o_done, o_fault}), 0);
    endtask

    row_t rows[10];

    initial begin
        rows[0] = '{2800, 1, 0, 1, 1,  8, 0,  8, 1, 0, 3};
        rows[1] = '{5600, 0, 1, 1, 1,  0, 7,  7, 1, 0, 3};
        rows[2] = '{5500, 1, 0, 1, 1,  0, 0,  0, 1, 0, 0};
        rows[3] = '{5432, 1, 0, 1, 1,  1, 0,  1, 1, 0, 3};
        rows[4] = '{5433, 1, 0, 1, 1,  0, 0,  0, 1, 0, 0};
        rows[5] = '{2968, 0, 1, 1, 1,  0, 1,  1, 1, 0, 3};
        rows[6] = '{2967, 0, 1, 1, 1,  0, 0,  0, 1, 0, 0};
        rows[7] = '{2800, 1, 0, 1, 0, 12, 0, 12, 0, 1, 0};
        rows[8] = '{2800, 1, 0, 0, 1,  0, 0, 12, 0, 0, 0};
        rows[9] = '{4000, 1, 1, 1, 1,  0, 0, 12, 0, 0, 0};

        reset = 1; req_fill = 0; req_drain = 0; abort = 0; doors = 1; water = 32'd2800;
        clear_op();
        step(); step();
        chk_reset_outputs("reset_init");
        reset = 0;
        step();

        for (int i = 0; i < 10; i++) begin
            water = rows[i].level; doors = rows[i].doors; model_on = rows[i].model;
            clear_op();
            if (rows[i].exp_done || rows[i].exp_fault)
                sb.push_back('{rows[i].exp_fault, rows[i].pcount});
            req_fill = rows[i].fill; req_drain = rows[i].drain; req_cyc = cyc;
            step();
            req_fill = 0; req_drain = 0;
            if (rows[i].exp_done || rows[i].exp_fault) begin
                wait_event($sformatf("row%0d", i));
                if (rows[i].exp_fault) begin
                    chk($sformatf("row%0d_fault_state", i), int'(o_state), 5);
                    repeat (3) step();
                    chk($sformatf("row%0d_fault_held", i), int'(o_fault), 1);
                    abort = 1; step(); abort = 0;
                end
                chk($sformatf("row%0d_end_idle", i), int'(o_state), 0);
            end else begin
                repeat (10) step();
                chk($sformatf("row%0d_ignored", i), int'(o_state), 0);
            end
            chk($sformatf("row%0d_n_inc", i), n_inc, rows[i].n_inc);
            chk($sformatf("row%0d_n_dec", i), n_dec, rows[i].n_dec);
            chk($sformatf("row%0d_done_cycles", i), n_done, int'(rows[i].exp_done));
            chk($sformatf("row%0d_settle_cycles", i), n_settle, rows[i].settle);
            chk($sformatf("row%0d_pcount_hold", i), int'(o_pulse_count), rows[i].pcount);
            if (rows[i].n_inc + rows[i].n_dec > 0)
                chk($sformatf("row%0d_first_pulse", i), first_cyc - req_cyc, 2);
            model_on = 1; doors = 1;
        end

        // Interlock: doors open after the 3rd fill pulse.
        water = 2800; clear_op();
        req_fill = 1; step(); req_fill = 0;
        for (int k = 0; k < 50 && n_inc < 3; k++) step();
        doors = 0;
        sb.push_back('{1'b1, 3});
        step();
        step();
        chk("interlock_fault_state", int'(o_state), 5);
        repeat (4) step();
        chk("interlock_no_more_pulses", n_inc, 3);
        chk("interlock_fault_held", int'(o_fault), 1);
        abort = 1; step(); abort = 0; doors = 1;
        chk("interlock_abort_idle", int'({o_state, o_fault}), 0);
        chk("interlock_event_seen", int'(ev_seen), 1);

        // Abort mid-drain: back to IDLE, no done, no fault.
        water = 5600; clear_op();
        req_drain = 1; step(); req_drain = 0;
        for (int k = 0; k < 50 && n_dec < 2; k++) step();
        abort = 1; step(); abort = 0;
        repeat (6) step();
        chk("abort_idle", int'(o_state), 0);
        chk("abort_no_more_pulses", n_dec, 2);
        chk("abort_no_done", n_done, 0);

        // Band lost during SETTLE: resume filling and keep the pulse tally.
        water = 2800; clear_op(); spacing_en = 0;
        sb.push_back('{1'b0, 10});
        req_fill = 1; step(); req_fill = 0;
        for (int k = 0; k < 100 && s_state != 3'd3; k++) step();
        water = 5000;
        wait_event("settle_loss");
        chk("settle_loss_n_inc", n_inc, 10);
        chk("settle_loss_idle", int'(o_state), 0);

        // Reset mid-fill, then conflicting requests.
        water = 2800; clear_op();
        req_fill = 1; step(); req_fill = 0;
        repeat (4) step();
        reset = 1; step();
        chk_reset_outputs("reset_midfill");
        reset = 0; clear_op();
        req_fill = 1; req_drain = 1;
        repeat (6) begin
            step();
            chk("conflict_idle", int'(s_state), 0);
        end
        req_fill = 0; req_drain = 0;
        chk("conflict_no_pulses", n_inc + n_dec, 0);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/lock_pump_sequencer.md
Name: lock_pump_sequencer

Overview:
Automatic pump controller directly upstream of the lock's water system. On a fill or drain request it issues rate-limited single-cycle inc/dec pulses until the water level reaches the openable band of the target door. It enforces a doors-closed interlock and a pulse budget. It reports busy, done and fault to the gondola controller and the operator LEDs.

Parameters:
INNER, 5600, inner (high) water level target
OUTER, 2800, outer (low) water level target
TOLERANCE, 168, openable band half-width
PUMP_PERIOD, 2, cycles between pulses; minimum 2, because water_level lags a pulse by one cycle
SETTLE_CYCLES, 3, cycles held in SETTLE before DONE
MAX_PULSES, 12, pulse budget per operation before FAULT

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_fill  in  1  level-sampled request to raise water to the inner band
req_drain  in  1  level-sampled request to lower water to the outer band
abort  in  1  cancel the current operation / clear FAULT
doors_closed  in  1  high when both lock doors are shut
water_level  in  32  current level (unsigned) from the water system
inc_pulse  out  1  one-cycle increment command
dec_pulse  out  1  one-cycle decrement command
busy  out  1  high in FILL, DRAIN, SETTLE
done  out  1  one-cycle completion strobe
fault  out  1  high while in FAULT
state  out  3  IDLE=0 FILL=1 DRAIN=2 SETTLE=3 DONE=4 FAULT=5
pulse_count  out  8  pulses issued in the current operation

Behaviour:
- Reset: state=IDLE; inc_pulse, dec_pulse, busy, done, fault = 0; pulse_count=0; internal phase counter=0. Reset overrides everything in any state.
- at_inner = water_level > INNER-TOLERANCE. at_outer = water_level < OUTER+TOLERANCE. Both comparisons are strict and unsigned.
- IDLE:
  - req_fill and req_drain both high: ignored, stay IDLE.
  - req_fill only, doors_closed=1: go to DONE if at_inner, else FILL.
  - req_drain only, doors_closed=1: go to DONE if at_outer, else DRAIN.
  - Request while doors_closed=0: ignored.
  - On entry to FILL/DRAIN: pulse_count=0, phase=0.
- FILL/DRAIN, evaluated each cycle in this priority order:
  1. abort: go to IDLE, no pulse.
  2. doors_closed=0: go to FAULT, no pulse.
  3. Target reached (at_inner for FILL, at_outer for DRAIN): go to SETTLE, no pulse.
  4. pulse_count==MAX_PULSES: go to FAULT.
  5. Otherwise, if phase==PUMP_PERIOD-1: assert inc_pulse (FILL) or dec_pulse (DRAIN) this cycle, increment pulse_count, set phase=0. Else phase+1.
- Pulse timing: the first pulse falls in the PUMP_PERIOD-th cycle spent in FILL/DRAIN. inc_pulse and dec_pulse are never high together.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then goes to DONE.
  - abort goes to IDLE.
  - doors_closed=0 goes to FAULT.
  - If the target band is lost during SETTLE: return to the originating FILL/DRAIN with phase=0; pulse_count is kept.
- DONE: done=1 for exactly one cycle, then IDLE. pulse_count holds its value until the next operation starts.
- FAULT: fault=1. Stays until abort=1, then IDLE. Requests are ignored while in FAULT.
- Requests arriving while busy are ignored, not queued.
- pulse_count saturates at 255; it is not reachable with legal MAX_PULSES.
- busy is derived from state, with no extra cycle of latency.

Test Plan:
The bench water model uses INC_AMT=350 and DEC_AMT=400, and updates water_level one cycle after each pulse, clamped to [2800, 5600].
- Fill: level=2800, doors_closed=1, req_fill pulse. Required: 8 inc_pulse, spaced 2 cycles apart, level reaches 5600, SETTLE for 3 cycles, one done strobe, pulse_count=8, no dec_pulse.
- Drain: level=5600, req_drain. Required: 7 dec_pulse, level reaches 2800, done, pulse_count=7.
- Already in band: level=5500, req_fill. Required: IDLE, then DONE, then IDLE; zero pulses; done high 1 cycle.
- Interlock: drop doors_closed after the 3rd inc_pulse of a fill. Required: FAULT the next cycle, no further pulses, fault held until abort, then IDLE.
- Timeout: model ignores pulses and level stays at 2800. Required: 12 inc_pulse, then FAULT with pulse_count=12.
- Reset and conflicts: assert reset mid-FILL. Required: next cycle all outputs 0 and state=0. Then raise req_fill and req_drain together. Required: stays IDLE.
